spi_scene_host: RTL and testbench

SPI mode-0 host that serialises one complete scene frame (background colour, polygon colour, three vertices, polygon-enable) into the GPU frontend's SPI slave port. It runs in the bench and the FPGA bring-up harness, on the driving side of `cs/sck/mosi/miso`. It also captures the slave's `miso` stream into a readback register. A frame is launched by a single-cycle start; done/busy report completion.

---
 rtl/spi_scene_pkg.sv | 58 +++++
 rtl/spi_scene_host_sck_gen.sv | 50 +++++
 rtl/spi_scene_host.sv | 157 +++++++++++++++
 tb/tb_spi_scene_host.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_scene_pkg.sv
// Shared frame layout and FSM encoding for the SPI scene host and the
// frontend receiver, so both ends agree on the 98-bit frame.
package spi_scene_pkg;

  localparam int FRAME_BITS = 98;

  localparam int BG_W   = 6;
  localparam int POLY_W = 12;
  localparam int X_W    = 14;
  localparam int Y_W    = 12;
  localparam int EN_W   = 2;

  localparam int EN_OFF   = 0;
  localparam int V2Y_OFF  = EN_OFF + EN_W;
  localparam int V2X_OFF  = V2Y_OFF + Y_W;
  localparam int V1Y_OFF  = V2X_OFF + X_W;
  localparam int V1X_OFF  = V1Y_OFF + Y_W;
  localparam int V0Y_OFF  = V1X_OFF + X_W;
  localparam int V0X_OFF  = V0Y_OFF + Y_W;
  localparam int POLY_OFF = V0X_OFF + X_W;
  localparam int BG_OFF   = POLY_OFF + POLY_W;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  function automatic frame_t pack_frame(
    input logic [BG_W-1:0]   bg,
    input logic [POLY_W-1:0] poly,
    input logic [X_W-1:0]    v0x,
    input logic [Y_W-1:0]    v0y,
    input logic [X_W-1:0]    v1x,
    input logic [Y_W-1:0]    v1y,
    input logic [X_W-1:0]    v2x,
    input logic [Y_W-1:0]    v2y,
    input logic [EN_W-1:0]   en
  );
    frame_t f;
    f = '0;
    f[BG_OFF   +: BG_W]   = bg;
    f[POLY_OFF +: POLY_W] = poly;
    f[V0X_OFF  +: X_W]    = v0x;
    f[V0Y_OFF  +: Y_W]    = v0y;
    f[V1X_OFF  +: X_W]    = v1x;
    f[V1Y_OFF  +: Y_W]    = v1y;
    f[V2X_OFF  +: X_W]    = v2x;
    f[V2Y_OFF  +: Y_W]    = v2y;
    f[EN_OFF   +: EN_W]   = en;
    return f;
  endfunction

endpackage

// File: rtl/spi_scene_host_sck_gen.sv
// SCK half-period generator: toggles the clock level every CLK_DIV cycles
// and flags the cycle whose closing edge raises or drops SCK.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       wrap;

  assign wrap   = en_i && (cnt_q == LAST);
  assign rise_o = wrap && !sck_q;
  assign fall_o = wrap && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_scene_host.sv
// SPI mode-0 host: shifts one 98-bit scene frame out on mosi and
// captures the slave's miso stream into rx_frame_out.
import spi_scene_pkg::*;

module spi_scene_host #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [BG_W-1:0]       bg_color_in,
  input  logic [POLY_W-1:0]     poly_color_in,
  input  logic [X_W-1:0]        v0_x_in,
  input  logic [Y_W-1:0]        v0_y_in,
  input  logic [X_W-1:0]        v1_x_in,
  input  logic [Y_W-1:0]        v1_y_in,
  input  logic [X_W-1:0]        v2_x_in,
  input  logic [Y_W-1:0]        v2_y_in,
  input  logic [EN_W-1:0]       poly_enable_in,
  input  logic                  miso_in,
  output logic                  cs_out,
  output logic                  sck_out,
  output logic                  mosi_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [FRAME_BITS-1:0] rx_frame_out
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [6:0] bit_q, bit_d;
  logic [7:0] gap_q, gap_d;
  frame_t     tx_q, tx_d;
  frame_t     rx_q, rx_d;
  frame_t     rxf_q, rxf_d;
  logic       cs_q, cs_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic sck_en, sck_clr, rise, fall, active_d;

  assign sck_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                  (state_q == ST_HOLD);
  // The rise strobe at the end of HOLD is the frame end, not a real edge.
  assign sck_clr = sck_en && (abort_in || ((state_q == ST_HOLD) && rise));

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (sck_en),
    .clr_i  (sck_clr),
    .sck_o  (sck_out),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxf_d   = rxf_q;
    done_d  = 1'b0;
    if (state_q != ST_GAP) gap_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_in && !abort_in) begin
          tx_d = pack_frame(bg_color_in, poly_color_in,
                            v0_x_in, v0_y_in, v1_x_in, v1_y_in,
                            v2_x_in, v2_y_in, poly_enable_in);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (abort_in) begin
          state_d = ST_GAP;
        end else if (rise) begin
          rx_d    = {rx_q[FRAME_BITS-2:0], miso_in};
          bit_d   = 7'(FRAME_BITS - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort_in) begin
          state_d = ST_GAP;
        end else if (rise) begin
          rx_d = {rx_q[FRAME_BITS-2:0], miso_in};
        end else if (fall) begin
          if (bit_q == 7'd0) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q - 7'd1;
            tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (abort_in) begin
          state_d = ST_GAP;
        end else if (rise) begin
          rxf_d   = rx_q;
          done_d  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == LAST) state_d = ST_IDLE;
        else               gap_d   = gap_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
               (state_d == ST_HOLD);
    cs_d   = !active_d;
    busy_d = (state_d != ST_IDLE);
    mosi_d = active_d ? tx_d[FRAME_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxf_q   <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxf_q   <= rxf_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cs_out       = cs_q;
  assign mosi_out     = mosi_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign rx_frame_out = rxf_q;

endmodule

// File: tb/tb_spi_scene_host.sv
// Scoreboard bench for spi_scene_host: random frames, aborts, resets,
// plus a CLK_DIV=1 instance with miso looped back to mosi.
module tb_spi_scene_host;

  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort;
  logic [5:0]  bg;
  logic [11:0] poly;
  logic [13:0] v0x, v1x, v2x;
  logic [11:0] v0y, v1y, v2y;
  logic [1:0]  en;
  logic        miso = 1'b0;
  logic        cs, sck, mosi, busy, done;
  logic [97:0] rxf;

  logic        d1_start, d1_abort, d1_miso;
  logic        d1_cs, d1_sck, d1_mosi, d1_busy, d1_done;
  logic [97:0] d1_rx;

  assign d1_miso = d1_mosi;

  spi_scene_host #(.CLK_DIV(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_in(start), .abort_in(abort),
    .bg_color_in(bg), .poly_color_in(poly),
    .v0_x_in(v0x), .v0_y_in(v0y), .v1_x_in(v1x), .v1_y_in(v1y),
    .v2_x_in(v2x), .v2_y_in(v2y), .poly_enable_in(en),
    .miso_in(miso), .cs_out(cs), .sck_out(sck), .mosi_out(mosi),
    .busy_out(busy), .done_out(done), .rx_frame_out(rxf)
  );

  spi_scene_host #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_in(d1_start), .abort_in(d1_abort),
    .bg_color_in(bg), .poly_color_in(poly),
    .v0_x_in(v0x), .v0_y_in(v0y), .v1_x_in(v1x), .v1_y_in(v1y),
    .v2_x_in(v2x), .v2_y_in(v2y), .poly_enable_in(en),
    .miso_in(d1_miso), .cs_out(d1_cs), .sck_out(d1_sck),
    .mosi_out(d1_mosi), .busy_out(d1_busy), .done_out(d1_done),
    .rx_frame_out(d1_rx)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int done_seen = 0;

  typedef struct {
    logic [97:0] frame;
    int          t0;
    int          kind;
    int          ab;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [97:0] got,
                     input logic [97:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chki(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic rand_fields();
    bg   = 6'($urandom);
    poly = 12'($urandom);
    v0x  = 14'($urandom);
    v0y  = 12'($urandom);
    v1x  = 14'($urandom);
    v1y  = 12'($urandom);
    v2x  = 14'($urandom);
    v2y  = 12'($urandom);
    en   = 2'($urandom);
  endtask

  function automatic logic [97:0] cat_fields();
    return {bg, poly, v0x, v0y, v1x, v1y, v2x, v2y, en};
  endfunction

  // kind: 0 normal, 1 abort at t0+ab, 2 reset mid-frame
  task automatic launch(input int kind, input int ab, output int t0);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    e.frame = cat_fields();
    e.t0 = t0;
    e.kind = kind;
    e.ab = ab;
    q.push_back(e);
    if (kind == 0) exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    rand_fields();
  endtask

  task automatic wait_cyc(input int t);
    int g;
    g = 0;
    while (cyc < t && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Monitor / scoreboard for the CLK_DIV=D instance
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0;
  logic [97:0] got_tx, got_rx;
  logic [97:0] prev_rx = '0;
  int          rises, cs_start;
  int          exp_bf = -1;
  exp_t        m;

  always @(negedge clk) begin
    if (prev_cs && !cs) begin
      rises = 0;
      got_tx = '0;
      got_rx = '0;
      cs_start = cyc;
      miso = 1'($urandom);
    end
    if (!cs && !prev_sck && sck) begin
      got_tx = {got_tx[96:0], mosi};
      got_rx = {got_rx[96:0], miso};
      rises++;
    end
    if (prev_sck && !sck) miso = 1'($urandom);
    if (done) done_seen++;
    if (!prev_cs && cs) begin
      if (q.size() == 0) begin
        chki("unexpected_frame", 1, 0);
      end else begin
        m = q.pop_front();
        chki("end_kind", done ? 0 : 1, (m.kind == 0) ? 0 : 1);
        if (m.kind == 0) begin
          chk("tx_frame", got_tx, m.frame);
          chk("rx_frame", rxf, got_rx);
          chki("sck_rises", rises, 98);
          chki("cs_low_len", cyc - cs_start, 197 * D);
          chki("done_time", cyc, m.t0 + 197 * D + 1);
          prev_rx = got_rx;
          exp_bf = cyc + D;
        end else if (m.kind == 1) begin
          chki("abort_cs_time", cyc, m.t0 + m.ab + 1);
          chk("abort_rx_kept", rxf, prev_rx);
          chk("abort_sck_low", sck, 0);
          exp_bf = cyc + D;
        end else begin
          chk("reset_rx_zero", rxf, 0);
          prev_rx = '0;
          exp_bf = -1;
        end
      end
    end
    if (prev_busy && !busy && exp_bf >= 0) begin
      chki("busy_fall", cyc, exp_bf);
      exp_bf = -1;
    end
    prev_cs = cs;
    prev_sck = sck;
    prev_busy = busy;
  end

  // CS activity tracker for the CLK_DIV=1 instance
  logic d1_prev_cs = 1'b1;
  int   d1_cnt = 0, d1_len = 0, d1_falls = 0, d1_dones = 0;

  always @(negedge clk) begin
    if (d1_prev_cs && !d1_cs) begin
      d1_falls++;
      d1_cnt = 1;
    end else if (!d1_cs) begin
      d1_cnt++;
    end
    if (!d1_prev_cs && d1_cs) d1_len = d1_cnt;
    if (d1_done) d1_dones++;
    d1_prev_cs = d1_cs;
  end

  initial begin
    int t0, a, g;
    logic [97:0] f;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    d1_start = 1'b0;
    d1_abort = 1'b0;
    rand_fields();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rxf, 0);
    rst_n = 1'b1;

    bg = 6'h2A; poly = 12'hF0F;
    v0x = 14'h1234; v0y = 12'hABC;
    v1x = 14'h0001; v1y = 12'h001;
    v2x = 14'h3FFF; v2y = 12'hFFF;
    en = 2'b11;
    launch(0, 0, t0);
    wait_idle();

    repeat (4) begin
      rand_fields();
      launch(0, 0, t0);
      wait_idle();
    end

    rand_fields();
    launch(0, 0, t0);
    wait_cyc(t0 + 100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    rand_fields();
    launch(1, 50, t0);
    wait_cyc(t0 + 50);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle();
    rand_fields();
    launch(0, 0, t0);
    wait_idle();

    rand_fields();
    launch(2, 0, t0);
    wait_cyc(t0 + 1 + D * 81);
    chk("sck_high_bit40", sck, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cs", cs, 1);
    chk("async_rst_sck", sck, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_fields();
    launch(0, 0, t0);
    wait_idle();

    repeat (3) begin
      a = int'($urandom_range(394, 1));
      rand_fields();
      launch(1, a, t0);
      wait_cyc(t0 + a);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_idle();
      rand_fields();
      launch(0, 0, t0);
      wait_idle();
    end

    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    d1_start = 1'b1;
    d1_abort = 1'b1;
    @(posedge clk); #1;
    d1_start = 1'b0;
    d1_abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chki("d1_no_cs", d1_falls, 0);
    chk("d1_no_busy", d1_busy, 0);
    rand_fields();
    f = cat_fields();
    d1_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    d1_start = 1'b0;
    rand_fields();
    g = 0;
    while (d1_busy && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    chki("d1_busy_fall", cyc, t0 + 199);
    chki("d1_cs_len", d1_len, 197);
    chki("d1_falls", d1_falls, 1);
    chki("d1_dones", d1_dones, 1);
    chk("d1_rx_loop", d1_rx, f);

    repeat (5) @(posedge clk);
    chki("done_count", done_seen, exp_done);
    chki("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
